simple_lsu: RTL and testbench
=============================

Name: simple_lsu

Overview:
- Load/store unit sitting directly upstream of simple_dmem in the simple ISA datapath.
- Accepts one memory request at a time from the execute stage over a valid/ready handshake.
- Drives the dmem write-enable, address and data ports, and absorbs the dmem's 1-cycle sequential read latency.
- Returns exactly one registered response per request (load data or store ack) over a valid/ready handshake to writeback.

Parameters:
- ADDR_W, 8, address width; must equal dmem address width.
- DATA_W, 8, data width; must equal dmem data width.
- ADDR_LIMIT, 256, first illegal address; used only when LSU_BOUNDS_CHECK_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  DATA_W  load data; 0 for stores.
- rsp_err  output  1  access fault (see Optional Feature).
- dmem_wren  output  1  to dmem write enable.
- dmem_addr  output  ADDR_W  to dmem common address.
- dmem_din  output  DATA_W  to dmem write data.
- dmem_dout  input  DATA_W  from dmem; valid the cycle after the address is presented.

Behaviour:
- Reset: one clock (clk), reset asynchronous active-low on resetn.
  - Asserting resetn low immediately forces state IDLE and clears rsp_valid, rsp_rdata, rsp_err and the dmem_addr register to 0.
  - dmem_wren is 0 while in reset.
  - Any in-flight request or unconsumed response is discarded.
- FSM states: IDLE, LOAD_WAIT, RSP_HOLD.
- req_ready = (state==IDLE) | (state==RSP_HOLD & rsp_ready). A request is accepted on a cycle where req_valid & req_ready ("accept", cycle T).
- dmem drive (combinational on accept):
  - dmem_addr = req_addr, dmem_din = req_wdata, dmem_wren = req_we.
  - On all other cycles: dmem_wren = 0, and dmem_addr/dmem_din hold the last accepted values from registers.
  - dmem_wren is never high for more than one cycle per store.
- Store accepted at T:
  - Memory is written at the T edge.
  - Next state RSP_HOLD; rsp_valid=1, rsp_rdata=0, rsp_err=0 from T+1.
- Load accepted at T:
  - Next state LOAD_WAIT (T+1). In LOAD_WAIT, dmem_dout is captured into rsp_rdata at the end of T+1.
  - Next state RSP_HOLD; rsp_valid=1 from T+2.
  - req_ready=0 in LOAD_WAIT.
- RSP_HOLD:
  - rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On rsp_ready with no new accept: go to IDLE and clear rsp_valid.
  - On rsp_ready with a same-cycle accept: take the new request's transition (back-to-back, no bubble).
- Throughput: stores 1 per cycle with rsp_ready held high; loads 1 per 2 cycles.
- Ordering: responses return in request order, since only one request is outstanding.
- Read-after-write: a store at T followed by a load to the same address at T+1 or later returns the stored value. The dmem read-before-write timing is therefore never exposed.
- req_* inputs are ignored when req_ready=0; the LSU does not require them stable.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined:
  - An accepted request with req_addr >= ADDR_LIMIT is faulted: dmem_wren stays 0 and the dmem_addr register is not updated.
  - Next state RSP_HOLD with rsp_err=1 and rsp_rdata=0, rsp_valid from T+1, for both loads and stores.
  - Legal addresses behave as above with rsp_err=0.
- Undefined: rsp_err is tied 0, ADDR_LIMIT is unused, and all 256 addresses are legal.

Test Plan:
- Reset mid-load: accept load addr 0x10, drop resetn at T+1 -> rsp_valid=0 immediately and stays 0 after release; req_ready=1 on the first cycle after reset release.
- Store/load round trip: store 0xA5 @0x3C at T, load @0x3C at T+1 with rsp_ready=1 -> store ack rsp_valid at T+1 with rdata 0; load rsp_valid at T+3 with rdata 0xA5; dmem_wren high only at T.
- Backpressure: load @0x3C with rsp_ready=0 for 5 cycles, req_valid held high -> rsp_valid/rdata=0xA5 stable throughout; req_ready=0; no dmem_wren pulses; next request accepted on the cycle rsp_ready rises.
- Back-to-back stores: 4 stores (0x00..0x03 <- 0x11..0x44), rsp_ready=1 -> one accept per cycle, 4 acks in order; loads 0x00..0x03 then return 0x11, 0x22, 0x33, 0x44.
- Address wrap/edge: store 0xFF @0xFF, load @0xFF and @0x00 -> 0xFF and the previously written value @0x00.
- With LSU_BOUNDS_CHECK_EN, ADDR_LIMIT=0x80: store 0x77 @0x90 -> rsp_err=1, dmem_wren never high; load @0x7F -> rsp_err=0 with correct data.

Source files
------------

// File: rtl/simple_lsu.sv
// Load/store unit between the execute stage and simple_dmem: one request at a time.
// It absorbs the dmem's 1-cycle read latency and returns one registered response per request.
// Optional macro LSU_BOUNDS_CHECK_EN faults any access at or above ADDR_LIMIT.
module simple_lsu #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_LIMIT = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  input  logic [DATA_W-1:0] dmem_dout
);

  typedef enum logic [1:0] {StIdle, StLoadWait, StRspHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              accept, fault, legal_acc;

`ifdef LSU_BOUNDS_CHECK_EN
  assign fault = 32'(req_addr) >= ADDR_LIMIT;
`else
  // Every address is legal; the limit is referenced only to keep the parameter alive.
  assign fault = (32'(req_addr) >= ADDR_LIMIT) & 1'b0;
`endif

  assign accept    = req_valid & req_ready;
  assign legal_acc = accept & ~fault;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (legal_acc) begin
        addr_q <= req_addr;
        din_q  <= req_wdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle, StRspHold: begin
        if (accept) begin
          rsp_rdata_d = '0;
          rsp_err_d   = fault;
          if (fault || req_we) begin
            state_d     = StRspHold;
            rsp_valid_d = 1'b1;
          end else begin
            state_d     = StLoadWait;
            rsp_valid_d = 1'b0;
          end
        end else if (state_q == StRspHold && rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      StLoadWait: begin
        // dmem_dout now reflects the address presented on the accept edge.
        state_d     = StRspHold;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = dmem_dout;
        rsp_err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready = (state_q == StIdle) | ((state_q == StRspHold) & rsp_ready);
    dmem_wren = legal_acc & req_we & resetn;
    dmem_addr = legal_acc ? req_addr : addr_q;
    dmem_din  = legal_acc ? req_wdata : din_q;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_simple_lsu.sv
// Bench for simple_lsu: behavioural dmem, queue scoreboard fed at accept and drained by a monitor,
// directed scenarios followed by randomized traffic with random response backpressure.
module tb_simple_lsu;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
`ifdef LSU_BOUNDS_CHECK_EN
  localparam int unsigned LIMIT = 'h80;
`else
  localparam int unsigned LIMIT = 256;
`endif

  logic          clk, resetn;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          dmem_wren;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_din, dmem_dout;

  simple_lsu #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem_wren(dmem_wren), .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read dmem: read-before-write, data visible one cycle after the address.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (dmem_wren) mem[dmem_addr] <= dmem_din;
    dmem_dout <= mem[dmem_addr];
  end

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [256];
  int            errors, checks;
  bit            rand_mode;
  bit            hold_pend;
  rsp_t          hold_v;

  function automatic bit legal(input logic [AW-1:0] a);
    return 32'(a) < LIMIT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a request and return once it has been accepted (1ns after the accept edge).
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        output int waits);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    waits     = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      if (waits >= 50) begin
        chk("req_accept_timeout", 32'(waits), 32'd0);
        break;
      end
      waits++;
      step();
    end
    step();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  // Monitor: model on accept, compare on response handshake, check hold stability and wren.
  task automatic monitor();
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        hold_pend = 1'b0;
      end else begin
        chk("dmem_wren", 32'(dmem_wren),
            32'(req_valid && req_ready && req_we && legal(req_addr)));
        if (req_valid && req_ready) begin
          if (legal(req_addr)) chk("dmem_addr", 32'(dmem_addr), 32'(req_addr));
          if (!legal(req_addr)) begin
            e.rdata = '0; e.err = 1'b1;
          end else if (req_we) begin
            ref_mem[req_addr] = req_wdata;
            e.rdata = '0; e.err = 1'b0;
          end else begin
            e.rdata = ref_mem[req_addr]; e.err = 1'b0;
          end
          exp_q.push_back(e);
        end
        if (hold_pend) begin
          chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          chk("rsp_hold_rdata", 32'(rsp_rdata), 32'(hold_v.rdata));
          chk("rsp_hold_err", 32'(rsp_err), 32'(hold_v.err));
        end
        hold_pend = 1'b0;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end else if (rsp_valid) begin
          hold_pend    = 1'b1;
          hold_v.rdata = rsp_rdata;
          hold_v.err   = rsp_err;
        end
      end
    end
  endtask

  initial begin
    int w;
    errors = 0; checks = 0; rand_mode = 1'b0; hold_pend = 1'b0;
    resetn = 1'b0; rsp_ready = 1'b1;
    idle();
    fork monitor(); join_none
    repeat (3) step();
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    step();

    // Fill every legal address so the reference model knows all contents.
    for (int a = 0; a < 256; a++)
      if (legal(AW'(a))) do_req(1'b1, AW'(a), DW'(a) ^ 8'h5A, w);
    idle();
    repeat (2) step();

    // Reset in the middle of a load.
    do_req(1'b0, 8'h10, 8'h00, w);
    idle();
    resetn = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_wren", 32'(dmem_wren), 32'd0);
    step(); step();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_rel_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("rst_rel_rsp_valid2", 32'(rsp_valid), 32'd0);

    // Store/load round trip with the load issued right behind the store.
    do_req(1'b1, 8'h3C, 8'hA5, w);
    chk("rt_store_ack_valid", 32'(rsp_valid), 32'd1);
    chk("rt_store_ack_rdata", 32'(rsp_rdata), 32'd0);
    do_req(1'b0, 8'h3C, 8'h00, w);
    chk("rt_load_b2b_wait", 32'(w), 32'd0);
    idle();
    chk("rt_loadwait_valid", 32'(rsp_valid), 32'd0);
    chk("rt_loadwait_ready", 32'(req_ready), 32'd0);
    step();
    chk("rt_load_valid", 32'(rsp_valid), 32'd1);
    chk("rt_load_rdata", 32'(rsp_rdata), 32'hA5);
    step();

    // Backpressure: response held while a new request waits.
    rsp_ready = 1'b0;
    do_req(1'b0, 8'h3C, 8'h00, w);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h3C; req_wdata = 8'h5B;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("bp_rdata", 32'(rsp_rdata), 32'hA5);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    idle();
    step();

    // Back-to-back stores, then loads of the same locations.
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, AW'(i), DW'((i + 1) * 'h11), w);
      chk("b2b_store_wait", 32'(w), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, AW'(i), 8'h00, w);
      chk("b2b_load_wait", 32'(w), (i == 0) ? 32'd0 : 32'd1);
    end
    idle();
    repeat (2) step();

    // Address edge.
    do_req(1'b1, 8'hFF, 8'hFF, w);
    do_req(1'b0, 8'hFF, 8'h00, w);
    do_req(1'b0, 8'h00, 8'h00, w);
    idle();
    repeat (2) step();

`ifdef LSU_BOUNDS_CHECK_EN
    do_req(1'b1, 8'h90, 8'h77, w);
    chk("bounds_err", 32'(rsp_err), 32'd1);
    do_req(1'b0, 8'h7F, 8'h00, w);
    idle();
    step();
    chk("bounds_legal_err", 32'(rsp_err), 32'd0);
    step();
`endif

    // Randomized traffic with random backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      do_req(1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
             DW'($urandom), w);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) step();
      end
    end
    idle();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
